// File: rtl/prefix_subtractor_pipe.sv
// Three-stage pipelined subtractor (a - b) on a Kogge-Stone prefix carry tree,
// with valid/ready flow control and borrow / signed-overflow / zero flags.
module prefix_subtractor_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  localparam int unsigned MSB    = WIDTH - 1;

  logic             s1_valid, s2_valid, s3_valid;
  logic             adv1, adv2, adv3;
  logic [WIDTH-1:0] s1_a, s1_bn;
  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] gk, pk, gn, pn;
  logic [WIDTH:0]   carry;
  logic [WIDTH:0]   s2_c;
  logic [WIDTH-1:0] s2_p;
  logic             s2_a_msb, s2_bn_msb;
  logic [WIDTH-1:0] sum;

  // A stage may advance when it is empty or its successor advances.
  assign adv3      = ~s3_valid | out_ready;
  assign adv2      = ~s2_valid | adv3;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s3_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv2) s2_valid <= s1_valid;
      if (adv3) s3_valid <= s2_valid;
    end
  end

  // Operand stage: minuend and inverted subtrahend.
  always_ff @(posedge clk) begin
    if (in_valid && adv1) begin
      s1_a  <= a;
      s1_bn <= ~b;
    end
  end

  // Prefix tree; the carry-in (G=1,P=0 at position -1) is folded into bit 0
  // up front so the tree needs only ceil(log2(WIDTH)) levels.
  always_comb begin
    p1    = s1_a ^ s1_bn;
    gk    = s1_a & s1_bn;
    pk    = p1;
    gk[0] = gk[0] | pk[0];
    pk[0] = 1'b0;
    gn    = gk;
    pn    = pk;
    for (int l = 0; l < int'(LEVELS); l++) begin
      gn = gk;
      pn = pk;
      for (int i = 1 << l; i < int'(WIDTH); i++) begin
        gn[i] = gk[i] | (pk[i] & gk[i - (1 << l)]);
        pn[i] = pk[i] & pk[i - (1 << l)];
      end
      gk = gn;
      pk = pn;
    end
    carry = {gk, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (adv2 && s1_valid) begin
      s2_c      <= carry;
      s2_p      <= p1;
      s2_a_msb  <= s1_a[MSB];
      s2_bn_msb <= s1_bn[MSB];
    end
  end

  assign sum = s2_p ^ s2_c[WIDTH-1:0];

  // Sum stage: registered result and flags, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (adv3 && s2_valid) begin
      diff   <= sum;
      borrow <= ~s2_c[WIDTH];
      ovf    <= (s2_a_msb ^ ~s2_bn_msb) & (sum[MSB] ^ s2_a_msb);
      zero   <= ~|sum;
    end
  end

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Scoreboard bench for prefix_subtractor_pipe: directed vectors at WIDTH=8,
// plus randomized traffic at WIDTH=13 and WIDTH=2.
module tb_prefix_subtractor_pipe;

  typedef struct {
    logic [15:0] d;
    logic        br;
    logic        ov;
    logic        z;
    int          cyc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic       in_valid, in_ready, out_valid, out_ready, borrow, ovf, zero;
  logic [7:0] a, b, diff;
  logic        in_valid13, in_ready13, out_valid13, out_ready13, borrow13, ovf13, zero13;
  logic [12:0] a13, b13, diff13;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, borrow2, ovf2, zero2;
  logic [1:0] a2, b2, diff2;

  exp_t q8[$];
  exp_t q13[$];
  exp_t q2[$];

  // Hand-computed vectors: a, b, diff, {borrow, ovf, zero}
  logic [7:0] tva [9] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h5A, 8'h37, 8'h00, 8'h00, 8'hFF};
  logic [7:0] tvb [9] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h5A, 8'h00, 8'h01, 8'h80, 8'hFF};
  logic [7:0] tvd [9] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'h00, 8'h37, 8'hFF, 8'h80, 8'h00};
  logic [2:0] tvf [9] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b000, 3'b100, 3'b110, 3'b001};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  prefix_subtractor_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .diff(diff), .borrow(borrow),
    .ovf(ovf), .zero(zero));

  prefix_subtractor_pipe #(.WIDTH(13)) u_dut13 (
    .clk(clk), .rst(rst), .in_valid(in_valid13), .in_ready(in_ready13), .a(a13), .b(b13),
    .out_valid(out_valid13), .out_ready(out_ready13), .diff(diff13), .borrow(borrow13),
    .ovf(ovf13), .zero(zero13));

  prefix_subtractor_pipe #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .diff(diff2), .borrow(borrow2),
    .ovf(ovf2), .zero(zero2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h time=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int w, input logic [15:0] x, input logic [15:0] y);
    exp_t        e;
    logic [15:0] m;
    m     = 16'((32'd1 << w) - 32'd1);
    e.d   = (x - y) & m;
    e.br  = (x < y);
    e.ov  = (x[w-1] != y[w-1]) && (e.d[w-1] != x[w-1]);
    e.z   = (e.d == 16'd0);
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [7:0] d, input logic [2:0] f);
    exp_t e;
    e.d   = 16'(d);
    e.br  = f[2];
    e.ov  = f[1];
    e.z   = f[0];
    e.cyc = 0;
    e.lat = 1'b1;
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send8(input logic [7:0] x, input logic [7:0] y, input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send8_in_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin
      e.cyc = cyc;
      q8.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while (q8.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain8_empty", 32'(q8.size()), 32'd0);
  endtask

  // Monitors: compare head of queue whenever a result is presented (also while stalled).
  always @(negedge clk) begin : mon8
    exp_t e;
    #2;
    if (!rst && out_valid) begin
      if (q8.size() == 0) begin
        chk("unexpected_out8", 32'(out_valid), 32'd0);
      end else begin
        e = q8[0];
        chk("diff8", 32'(diff), 32'(e.d));
        chk("borrow8", 32'(borrow), 32'(e.br));
        chk("ovf8", 32'(ovf), 32'(e.ov));
        chk("zero8", 32'(zero), 32'(e.z));
        if (out_ready) begin
          if (e.lat) chk("latency8", 32'(cyc), 32'(e.cyc + 3));
          q8.delete(0);
        end
      end
    end
  end

  always @(negedge clk) begin : mon13
    exp_t e;
    #2;
    if (!rst && out_valid13) begin
      if (q13.size() == 0) begin
        chk("unexpected_out13", 32'(out_valid13), 32'd0);
      end else begin
        e = q13[0];
        chk("diff13", 32'(diff13), 32'(e.d));
        chk("borrow13", 32'(borrow13), 32'(e.br));
        chk("ovf13", 32'(ovf13), 32'(e.ov));
        chk("zero13", 32'(zero13), 32'(e.z));
        if (out_ready13) q13.delete(0);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    #2;
    if (!rst && out_valid2) begin
      if (q2.size() == 0) begin
        chk("unexpected_out2", 32'(out_valid2), 32'd0);
      end else begin
        e = q2[0];
        chk("diff2", 32'(diff2), 32'(e.d));
        chk("borrow2", 32'(borrow2), 32'(e.br));
        chk("ovf2", 32'(ovf2), 32'(e.ov));
        chk("zero2", 32'(zero2), 32'(e.z));
        if (out_ready2) q2.delete(0);
      end
    end
  end

  initial begin
    exp_t       e;
    int         acc, refused, nv;
    logic [7:0] x, y;

    rst = 1'b1;
    in_valid = 1'b0;  a = '0;   b = '0;   out_ready = 1'b1;
    in_valid13 = 1'b0; a13 = '0; b13 = '0; out_ready13 = 1'b1;
    in_valid2 = 1'b0; a2 = '0;  b2 = '0;  out_ready2 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_flags", 32'({borrow, ovf, zero}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors, back-to-back
    for (int i = 0; i < 9; i++) send8(tva[i], tvb[i], mk(tvd[i], tvf[i]));
    drain8();

    // Stream of 10 pairs
    for (int i = 0; i < 10; i++) begin
      x = 8'(i * 37 + 11);
      y = 8'(i * 53 + 200);
      e = model(8, 16'(x), 16'(y));
      e.lat = 1'b1;
      send8(x, y, e);
    end
    drain8();

    // Backpressure: fill with out_ready low, keep offering changing operands
    out_ready = 1'b0;
    acc = 0;
    refused = 0;
    for (int k = 0; k < 8; k++) begin
      x = 8'(k * 29 + 3);
      y = 8'(k * 71 + 5);
      in_valid = 1'b1;
      a = x;
      b = y;
      #1;
      if (in_ready) begin
        e = model(8, 16'(x), 16'(y));
        e.cyc = cyc;
        q8.push_back(e);
        acc++;
      end else begin
        refused++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("accepts_before_full", 32'(acc), 32'd3);
    chk("refused_cycles", 32'(refused), 32'd5);
    out_ready = 1'b1;
    nv = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (out_valid) nv++;
      @(negedge clk);
    end
    chk("resume_no_gap", 32'(nv), 32'd3);
    drain8();

    // Reset with three results in flight
    for (int i = 0; i < 3; i++) begin
      x = 8'(i * 17 + 90);
      y = 8'(i * 5 + 1);
      e = model(8, 16'(x), 16'(y));
      send8(x, y, e);
    end
    rst = 1'b1;
    q8.delete();
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_flags", 32'({borrow, ovf, zero}), 32'd0);
    @(negedge clk);
    send8(8'h10, 8'h20, mk(8'hF0, 3'b100));
    drain8();

    // Random traffic on the WIDTH=13 and WIDTH=2 instances
    for (int k = 0; k < 400; k++) begin
      in_valid13  = 1'($urandom);
      a13         = 13'($urandom);
      b13         = 13'($urandom);
      out_ready13 = ($urandom_range(3) != 0);
      in_valid2   = 1'($urandom);
      a2          = 2'($urandom);
      b2          = 2'($urandom);
      out_ready2  = ($urandom_range(3) != 0);
      #1;
      if (in_valid13 && in_ready13) q13.push_back(model(13, 16'(a13), 16'(b13)));
      if (in_valid2 && in_ready2) q2.push_back(model(2, 16'(a2), 16'(b2)));
      @(negedge clk);
    end
    in_valid13 = 1'b0;
    out_ready13 = 1'b1;
    in_valid2 = 1'b0;
    out_ready2 = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain13_empty", 32'(q13.size()), 32'd0);
    chk("drain2_empty", 32'(q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
